// File: rtl/imem_dmem_arbiter.sv
// Shares one single-outstanding memory port between an instruction fetch port and a data port.
// Optional ARB_RR_EN macro: round-robin on contested grants instead of fixed data-port priority.
module imem_dmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    input  logic        imem_kill,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DROP  = 3'd4
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t      state_q;
    state_t      state_d;
    logic        owner_q;
    logic        imem_req;
    logic        dmem_req;
    logic        pick_d;
    logic        capture;
    logic        upd_rdata;
    logic        kill_hit;

    logic [31:0] req_addr;
    logic [3:0]  req_rmask;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;

`ifdef ARB_RR_EN
    logic        last_grant_q;
`endif

    assign imem_req = |imem_rmask;
    assign dmem_req = |(dmem_rmask | dmem_wmask);

    // pick_d: the data port wins the grant decided this cycle
    always_comb begin
`ifdef ARB_RR_EN
        pick_d = dmem_req && (!imem_req || (last_grant_q == OWN_I));
`else
        pick_d = dmem_req;
`endif
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        upd_rdata = 1'b0;
        kill_hit  = imem_kill && (owner_q == OWN_I);
        case (state_q)
            IDLE: begin
                if (imem_req || dmem_req) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (mem_resp) begin
                    // A flushed fetch whose data lands this cycle is simply dropped
                    if (kill_hit) begin
                        state_d = IDLE;
                    end else begin
                        upd_rdata = 1'b1;
                        state_d   = RESP;
                    end
                end else if (kill_hit) begin
                    state_d = DROP;
                end else if (state_q == ISSUE) begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DROP: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_D;
            imem_rdata <= 32'h0;
            dmem_rdata <= 32'h0;
`ifdef ARB_RR_EN
            last_grant_q <= OWN_D;
`endif
        end else begin
            state_q <= state_d;
            if (capture) begin
                owner_q <= pick_d;
`ifdef ARB_RR_EN
                last_grant_q <= pick_d;
`endif
            end
            if (upd_rdata) begin
                if (owner_q == OWN_D) begin
                    dmem_rdata <= mem_rdata;
                end else begin
                    imem_rdata <= mem_rdata;
                end
            end
        end
    end

    // Request payload is only meaningful while ISSUE presents it, so it carries no reset
    always_ff @(posedge clk) begin
        if (capture) begin
            if (pick_d) begin
                req_addr  <= dmem_addr;
                req_rmask <= dmem_rmask;
                req_wmask <= dmem_wmask;
                req_wdata <= dmem_wdata;
            end else begin
                req_addr  <= imem_addr;
                req_rmask <= imem_rmask;
                req_wmask <= 4'h0;
                req_wdata <= 32'h0;
            end
        end
    end

    always_comb begin
        mem_addr  = 32'h0;
        mem_rmask = 4'h0;
        mem_wmask = 4'h0;
        mem_wdata = 32'h0;
        if (state_q == ISSUE) begin
            mem_addr  = req_addr;
            mem_rmask = req_rmask;
            mem_wmask = req_wmask;
            mem_wdata = req_wdata;
        end
    end

    assign imem_resp = (state_q == RESP) && (owner_q == OWN_I);
    assign dmem_resp = (state_q == RESP) && (owner_q == OWN_D);

endmodule
